// File: rtl/myniosiicpu_sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package myniosiicpu_sysid_pkg;

   typedef enum logic [2:0] {
      ST_SETTLE  = 3'd0,
      ST_RD_ID   = 3'd1,
      ST_RD_TS   = 3'd2,
      ST_COMPARE = 3'd3,
      ST_PASS    = 3'd4,
      ST_FAIL    = 3'd5
   } state_e;

   localparam logic [31:0] DEF_EXPECTED_ID = 32'h0000_0000;
   localparam logic [31:0] DEF_EXPECTED_TS = 32'h5A44_6F3A;

   // Word addresses inside the sysid slave.
   localparam logic ID_ADDR = 1'b0;
   localparam logic TS_ADDR = 1'b1;

endpackage

// File: rtl/myniosiicpu_sysid_rd.sv
// Single-word Avalon-MM read engine with a waitrequest stall timeout.
// Latency: done/timed_out flag in the cycle the slave accepts or the stall limit is reached.
// Backpressure: holds read/address while waitrequest is high, for at most WAIT_TIMEOUT cycles.
module myniosiicpu_sysid_rd
   import myniosiicpu_sysid_pkg::*;
#(
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        go_i,
   input  logic        addr_i,
   output logic        done_o,
   output logic [31:0] data_o,
   output logic        timed_out_o,
   output logic        avm_read_o,
   output logic        avm_address_o,
   input  logic [31:0] avm_readdata_i,
   input  logic        avm_waitrequest_i
);

   localparam logic [15:0] STALL_LAST = 16'(WAIT_TIMEOUT - 1);

   logic [15:0] stall_q, stall_d;

   // go/addr come straight from registers in the sequencer, so the bus stays glitch-free.
   assign avm_read_o    = go_i;
   assign avm_address_o = addr_i;
   assign data_o        = avm_readdata_i;
   assign done_o        = go_i & ~avm_waitrequest_i;
   assign timed_out_o   = go_i & avm_waitrequest_i & (stall_q == STALL_LAST);

   // Count consecutive stalled cycles; any accept, abort or idle cycle restarts the count.
   always_comb begin
      stall_d = '0;
      if (go_i && avm_waitrequest_i && !timed_out_o)
         stall_d = stall_q + 16'd1;
   end

   // Stall counter register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) stall_q <= '0;
      else          stall_q <= stall_d;
   end

endmodule

// File: rtl/myniosiicpu_sysid_checker.sv
// Boot sequencer: reads sysid ID/timestamp, compares, retries, then latches a verdict that gates CPU reset.
// Latency: verdict SETTLE_CYCLES+3 cycles after reset with a zero-wait slave; +1 per stall cycle.
// Backpressure: honours sid_waitrequest per read, aborting an attempt after WAIT_TIMEOUT stalled cycles.
module myniosiicpu_sysid_checker
   import myniosiicpu_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TS,
   parameter bit          CHECK_TIMESTAMP    = 1'b1,
   parameter int          SETTLE_CYCLES      = 16,
   parameter int          MAX_RETRIES        = 3,
   parameter int          WAIT_TIMEOUT       = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   output logic        sid_address_o,
   output logic        sid_read_o,
   input  logic [31:0] sid_readdata_i,
   input  logic        sid_waitrequest_i,
   output logic        cpu_release_o,
   output logic        check_done_o,
   output logic        check_pass_o,
   output logic        id_mismatch_o,
   output logic        ts_mismatch_o,
   output logic        bus_timeout_o,
   output logic [31:0] read_id_o,
   output logic [31:0] read_ts_o,
   output logic [2:0]  attempts_o
);

   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] RETRY_LIM   = 16'(MAX_RETRIES);

   state_e      state_q, state_d;
   logic [15:0] settle_q, settle_d;
   logic [15:0] fails_q, fails_d;
   logic [2:0]  attempts_q, attempts_d;
   logic        id_mis_q, id_mis_d, ts_mis_q, ts_mis_d, tmo_q, tmo_d;
   logic        done_q, done_d, pass_q, pass_d, rel_q, rel_d;
   logic        rd_go_q, rd_go_d, rd_addr_q, rd_addr_d;
   logic [31:0] read_id_q, read_id_d, read_ts_q, read_ts_d;
   logic        rd_done, rd_tmo, attempt_ok;
   logic [31:0] rd_data;

   myniosiicpu_sysid_rd #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_rd (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .go_i              (rd_go_q),
      .addr_i            (rd_addr_q),
      .done_o            (rd_done),
      .data_o            (rd_data),
      .timed_out_o       (rd_tmo),
      .avm_read_o        (sid_read_o),
      .avm_address_o     (sid_address_o),
      .avm_readdata_i    (sid_readdata_i),
      .avm_waitrequest_i (sid_waitrequest_i)
   );

   // Next-state and output decode; every register holds unless a state says otherwise.
   always_comb begin
      state_d    = state_q;
      settle_d   = settle_q;
      fails_d    = fails_q;
      attempts_d = attempts_q;
      id_mis_d   = id_mis_q;
      ts_mis_d   = ts_mis_q;
      tmo_d      = tmo_q;
      done_d     = done_q;
      pass_d     = pass_q;
      rel_d      = rel_q;
      read_id_d  = read_id_q;
      read_ts_d  = read_ts_q;
      attempt_ok = 1'b0;
      case (state_q)
         ST_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d  = ST_RD_ID;
               settle_d = '0;
               tmo_d    = 1'b0;   // new attempt: timeout flag describes this one only
            end else begin
               settle_d = settle_q + 16'd1;
            end
         end
         ST_RD_ID: begin
            if (rd_done) begin
               read_id_d = rd_data;
               state_d   = ST_RD_TS;
            end else if (rd_tmo) begin
               tmo_d   = 1'b1;
               state_d = ST_COMPARE;
            end
         end
         ST_RD_TS: begin
            if (rd_done) begin
               read_ts_d = rd_data;
               state_d   = ST_COMPARE;
            end else if (rd_tmo) begin
               tmo_d   = 1'b1;
               state_d = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            id_mis_d   = (read_id_q != EXPECTED_ID);
            ts_mis_d   = CHECK_TIMESTAMP && (read_ts_q != EXPECTED_TIMESTAMP);
            attempts_d = (attempts_q == 3'd7) ? 3'd7 : attempts_q + 3'd1;
            attempt_ok = !tmo_q && !id_mis_d && !ts_mis_d;
            if (attempt_ok) begin
               state_d = ST_PASS;
               done_d  = 1'b1;
               pass_d  = 1'b1;
               rel_d   = 1'b1;
            end else begin
               fails_d = fails_q + 16'd1;
               if (fails_q < RETRY_LIM) begin
                  state_d  = ST_SETTLE;
                  settle_d = '0;
               end else begin
                  state_d = ST_FAIL;
                  done_d  = 1'b1;
                  pass_d  = 1'b0;
                  rel_d   = 1'b0;
               end
            end
         end
         ST_PASS, ST_FAIL: begin
            if (start_i) begin
               state_d    = ST_SETTLE;
               settle_d   = '0;
               fails_d    = '0;
               attempts_d = '0;
               id_mis_d   = 1'b0;
               ts_mis_d   = 1'b0;
               tmo_d      = 1'b0;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               rel_d      = 1'b0;
            end
         end
         default: state_d = ST_SETTLE;
      endcase
      // Bus strobes are registered from the next state so they line up with the state register.
      rd_go_d   = (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
      rd_addr_d = (state_d == ST_RD_TS) ? TS_ADDR : ID_ADDR;
   end

   // State and output registers; reset drops the bus strobe immediately.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_SETTLE;
         settle_q   <= '0;
         fails_q    <= '0;
         attempts_q <= '0;
         id_mis_q   <= 1'b0;
         ts_mis_q   <= 1'b0;
         tmo_q      <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         rel_q      <= 1'b0;
         rd_go_q    <= 1'b0;
         rd_addr_q  <= ID_ADDR;
         read_id_q  <= '0;
         read_ts_q  <= '0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         fails_q    <= fails_d;
         attempts_q <= attempts_d;
         id_mis_q   <= id_mis_d;
         ts_mis_q   <= ts_mis_d;
         tmo_q      <= tmo_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         rel_q      <= rel_d;
         rd_go_q    <= rd_go_d;
         rd_addr_q  <= rd_addr_d;
         read_id_q  <= read_id_d;
         read_ts_q  <= read_ts_d;
      end
   end

   assign cpu_release_o = rel_q;
   assign check_done_o  = done_q;
   assign check_pass_o  = pass_q;
   assign id_mismatch_o = id_mis_q;
   assign ts_mismatch_o = ts_mis_q;
   assign bus_timeout_o = tmo_q;
   assign read_id_o     = read_id_q;
   assign read_ts_o     = read_ts_q;
   assign attempts_o    = attempts_q;

endmodule
